// File: rtl/pipe_hz_pkg.sv
// Shared types for the ID-stage hazard/forwarding controller.
// Build option: PIPE_HZ_FWD_EN (enables bypass forwarding; otherwise stall-only).
package pipe_hz_pkg;

  // Tag storage width; the controller supports RBITS up to this value.
  localparam int HZ_RN_W   = 8;
  localparam int HZ_FSEL_W = 4;

  typedef struct packed {
    logic               wreg;
    logic [HZ_RN_W-1:0] wrn;
    logic               load;
  } hz_tag_t;

  typedef logic [HZ_FSEL_W-1:0] fwd_sel_t;

  // Forward select value that means "read the register file".
  localparam fwd_sel_t FWD_RF = '0;

endpackage

// File: rtl/pipe_mdu_track.sv
// Multiply/divide unit occupancy tracker: busy flag, down-counter to
// writeback, pending destination, and the hazards it raises against ID.
module pipe_mdu_track #(
  parameter int RBITS   = 5,
  parameter int MDU_LAT = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             issue,
  input  logic             is_mdu,
  input  logic             wr_any,
  input  logic [RBITS-1:0] wrn,
  input  logic             use_rs,
  input  logic [RBITS-1:0] rs,
  input  logic             use_rt,
  input  logic [RBITS-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [RBITS-1:0] pend_rn,
  output logic             raw_hz,
  output logic             waw_hz,
  output logic             struct_hz
);

  localparam int CW = $clog2(MDU_LAT + 1);

  logic [CW-1:0] cnt;
  logic          blocking;
  logic          pend_live;

  // Occupancy state: a new issue restarts the count even on the done edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy    <= 1'b0;
      cnt     <= '0;
      pend_rn <= '0;
    end else begin
      if (issue) begin
        busy    <= 1'b1;
        cnt     <= CW'(MDU_LAT);
        pend_rn <= wrn;
      end else begin
        if (cnt != '0) cnt <= cnt - CW'(1);
        if (done)      busy <= 1'b0;
      end
    end
  end

  // In the done cycle the result is already visible through the regfile,
  // so the pending register stops blocking anything.
  always_comb begin
    done      = busy && (cnt == CW'(1));
    blocking  = busy && !done;
    pend_live = blocking && (pend_rn != '0);
    raw_hz    = pend_live && ((use_rs && rs == pend_rn) || (use_rt && rt == pend_rn));
    waw_hz    = pend_live && wr_any && (wrn == pend_rn);
    struct_hz = blocking && is_mdu;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard, forwarding and MDU scoreboard. Keeps its own shift
// register of in-flight destination tags.
// Build option: PIPE_HZ_FWD_EN selects forwarding; undefined means any
// in-flight match stalls and forward selects stay at the regfile.
module pipe_hazard_ctrl
  import pipe_hz_pkg::*;
#(
  parameter int RBITS    = 5,
  parameter int NSTAGE   = 3,
  parameter int LD_STAGE = 2,
  parameter int MDU_LAT  = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      id_valid,
  input  logic [RBITS-1:0]          id_rs,
  input  logic [RBITS-1:0]          id_rt,
  input  logic                      id_use_rs,
  input  logic                      id_use_rt,
  input  logic                      id_wreg,
  input  logic [RBITS-1:0]          id_wrn,
  input  logic                      id_load,
  input  logic                      id_mdu,
  output logic [$clog2(NSTAGE)-1:0] fwda,
  output logic [$clog2(NSTAGE)-1:0] fwdb,
  output logic                      stall,
  output logic                      mdu_busy,
  output logic                      mdu_done,
  output logic [RBITS-1:0]          mdu_wrn
);

  localparam int FBITS = $clog2(NSTAGE);

  // Stage NSTAGE (W) is not tracked: the regfile write on negedge covers it.
  hz_tag_t           tag_q [1:NSTAGE-1];
  logic [NSTAGE-1:1] match_a, match_b;
  logic              issue, data_hz;
  logic              raw_hz, waw_hz, struct_hz;

  assign issue = id_valid && !stall;
  assign stall = id_valid && (data_hz || raw_hz || waw_hz || struct_hz);

  pipe_mdu_track #(
    .RBITS   (RBITS),
    .MDU_LAT (MDU_LAT)
  ) u_mdu (
    .clock     (clock),
    .resetn    (resetn),
    .issue     (issue && id_mdu),
    .is_mdu    (id_mdu),
    .wr_any    (id_wreg || id_mdu),
    .wrn       (id_wrn),
    .use_rs    (id_use_rs),
    .rs        (id_rs),
    .use_rt    (id_use_rt),
    .rt        (id_rt),
    .busy      (mdu_busy),
    .done      (mdu_done),
    .pend_rn   (mdu_wrn),
    .raw_hz    (raw_hz),
    .waw_hz    (waw_hz),
    .struct_hz (struct_hz)
  );

  // Tag shift register: advances every cycle, a stalled ID injects a bubble.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 1; k < NSTAGE; k++) tag_q[k] <= '0;
    end else begin
      tag_q[1] <= issue ? '{wreg: id_wreg && !id_mdu, wrn: HZ_RN_W'(id_wrn), load: id_load}
                        : '0;
      for (int k = 2; k < NSTAGE; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // Per-stage operand match; r0 never matches.
  always_comb begin
    for (int k = 1; k < NSTAGE; k++) begin
      match_a[k] = id_use_rs && tag_q[k].wreg && (tag_q[k].wrn == HZ_RN_W'(id_rs)) && (id_rs != '0);
      match_b[k] = id_use_rt && tag_q[k].wreg && (tag_q[k].wrn == HZ_RN_W'(id_rt)) && (id_rt != '0);
    end
  end

`ifdef PIPE_HZ_FWD_EN
  logic [FBITS-1:0] sel_a, sel_b;
  logic             ld_hz;

  // Youngest producer wins: scan oldest to youngest so the last hit sticks.
  always_comb begin
    sel_a = FBITS'(FWD_RF);
    sel_b = FBITS'(FWD_RF);
    ld_hz = 1'b0;
    for (int k = NSTAGE - 1; k >= 1; k--) begin
      if (match_a[k]) sel_a = FBITS'(k);
      if (match_b[k]) sel_b = FBITS'(k);
      if ((match_a[k] || match_b[k]) && tag_q[k].load && (k < LD_STAGE)) ld_hz = 1'b1;
    end
  end

  assign data_hz = ld_hz;
  assign fwda    = id_valid ? sel_a : FBITS'(FWD_RF);
  assign fwdb    = id_valid ? sel_b : FBITS'(FWD_RF);
`else
  logic [NSTAGE-1:0] unused_load;

  // Load timing is irrelevant when every in-flight match waits for writeback.
  always_comb begin
    unused_load[0] = id_load;
    for (int k = 1; k < NSTAGE; k++) unused_load[k] = tag_q[k].load;
  end

  assign data_hz = |(match_a | match_b);
  assign fwda    = FBITS'(FWD_RF);
  assign fwdb    = FBITS'(FWD_RF);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl at default parameters.
module tb_pipe_hazard_ctrl;

  localparam int RBITS  = 5;
  localparam int NSTAGE = 3;
  localparam int FBITS  = 2;

  logic             clock = 1'b0;
  logic             resetn;
  logic             id_valid, id_use_rs, id_use_rt, id_wreg, id_load, id_mdu;
  logic [RBITS-1:0] id_rs, id_rt, id_wrn;
  logic [FBITS-1:0] fwda, fwdb;
  logic             stall, mdu_busy, mdu_done;
  logic [RBITS-1:0] mdu_wrn;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(
    .RBITS(RBITS), .NSTAGE(NSTAGE), .LD_STAGE(2), .MDU_LAT(4)
  ) dut (
    .clock(clock), .resetn(resetn), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_wrn(id_wrn), .id_load(id_load), .id_mdu(id_mdu),
    .fwda(fwda), .fwdb(fwdb), .stall(stall),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .mdu_wrn(mdu_wrn)
  );

  typedef struct packed {
    logic             stall;
    logic             care;
    logic [FBITS-1:0] fa;
    logic [FBITS-1:0] fb;
    logic             busy;
    logic             done;
    logic [RBITS-1:0] wrn;
  } exp_t;

  exp_t  q_exp[$];
  string q_tag[$];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input int v, input int rs, input int rt, input int urs, input int urt,
                       input int wreg, input int wrn, input int ld, input int mdu);
    id_valid  = 1'(v);
    id_rs     = RBITS'(rs);
    id_rt     = RBITS'(rt);
    id_use_rs = 1'(urs);
    id_use_rt = 1'(urt);
    id_wreg   = 1'(wreg);
    id_wrn    = RBITS'(wrn);
    id_load   = 1'(ld);
    id_mdu    = 1'(mdu);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Forward selects are only meaningful when not stalling.
  task automatic expect_out(input string tag, input int st, input int fa, input int fb,
                            input int busy, input int done, input int wrn);
    exp_t e;
    e.stall = 1'(st);
    e.care  = ~1'(st);
    e.fa    = FBITS'(fa);
    e.fb    = FBITS'(fb);
    e.busy  = 1'(busy);
    e.done  = 1'(done);
    e.wrn   = RBITS'(wrn);
    q_exp.push_back(e);
    q_tag.push_back(tag);
  endtask

  task automatic tick();
    exp_t  e;
    string t;
    @(negedge clock);
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    chk({t, "_stall"}, 32'(stall), 32'(e.stall));
    if (e.care) begin
      chk({t, "_fwda"}, 32'(fwda), 32'(e.fa));
      chk({t, "_fwdb"}, 32'(fwdb), 32'(e.fb));
    end
    chk({t, "_busy"}, 32'(mdu_busy), 32'(e.busy));
    chk({t, "_done"}, 32'(mdu_done), 32'(e.done));
    chk({t, "_wrn"},  32'(mdu_wrn),  32'(e.wrn));
    @(posedge clock);
    #1;
  endtask

  task automatic flush(input int n, input int wrn);
    for (int i = 0; i < n; i++) begin
      idle();
      expect_out("flush", 0, 0, 0, 0, 0, wrn);
      tick();
    end
  endtask

  initial begin
    resetn = 1'b0;
    drive(1, 3, 3, 1, 1, 1, 3, 1, 1);
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    tick();
    resetn = 1'b1;
    flush(1, 0);

    // ALU producer followed by dependent consumer
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
    expect_out("alu_prod", 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 3, 1, 1, 1, 1, 4, 0, 0);
`ifdef PIPE_HZ_FWD_EN
    expect_out("alu_fwd", 0, 1, 0, 0, 0, 0);
    tick();
`else
    expect_out("alu_st1", 1, 0, 0, 0, 0, 0);
    tick();
    expect_out("alu_st2", 1, 0, 0, 0, 0, 0);
    tick();
    expect_out("alu_go", 0, 0, 0, 0, 0, 0);
    tick();
`endif
    flush(2, 0);

    // load-use
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
    expect_out("lw_prod", 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 5, 2, 1, 1, 1, 6, 0, 0);
    expect_out("lw_st1", 1, 0, 0, 0, 0, 0);
    tick();
`ifdef PIPE_HZ_FWD_EN
    expect_out("lw_fwd", 0, 2, 0, 0, 0, 0);
    tick();
`else
    expect_out("lw_st2", 1, 0, 0, 0, 0, 0);
    tick();
    expect_out("lw_go", 0, 0, 0, 0, 0, 0);
    tick();
`endif
    flush(2, 0);

    // r0 is never a hazard
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    expect_out("r0_prod", 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 1, 1, 1, 7, 0, 0);
    expect_out("r0_use", 0, 0, 0, 0, 0, 0);
    tick();
    flush(2, 0);

    // two writers of r3 in flight, youngest wins on both operands
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
    expect_out("dbl_w1", 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
    expect_out("dbl_w2", 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 3, 3, 1, 1, 1, 11, 0, 0);
`ifdef PIPE_HZ_FWD_EN
    expect_out("dbl_fwd", 0, 1, 1, 0, 0, 0);
    tick();
`else
    expect_out("dbl_st1", 1, 0, 0, 0, 0, 0);
    tick();
    expect_out("dbl_st2", 1, 0, 0, 0, 0, 0);
    tick();
    expect_out("dbl_go", 0, 0, 0, 0, 0, 0);
    tick();
`endif
    flush(2, 0);

    // MDU to r8, consumer waits for the done cycle
    drive(1, 0, 0, 0, 0, 0, 8, 0, 1);
    expect_out("mdu_iss", 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 8, 0, 1, 0, 1, 9, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_out("mdu_raw", 1, 0, 0, 1, 0, 8);
      tick();
    end
    expect_out("mdu_done", 0, 0, 0, 1, 1, 8);
    tick();
    flush(2, 8);

    // structural hazard, then WAW against the second op
    drive(1, 0, 0, 0, 0, 0, 8, 0, 1);
    expect_out("st_iss1", 0, 0, 0, 0, 0, 8);
    tick();
    idle();
    expect_out("st_gap", 0, 0, 0, 1, 0, 8);
    tick();
    drive(1, 0, 0, 0, 0, 0, 10, 0, 1);
    expect_out("st_blk1", 1, 0, 0, 1, 0, 8);
    tick();
    expect_out("st_blk2", 1, 0, 0, 1, 0, 8);
    tick();
    expect_out("st_iss2", 0, 0, 0, 1, 1, 8);
    tick();
    drive(1, 0, 0, 0, 0, 1, 10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_out("waw", 1, 0, 0, 1, 0, 10);
      tick();
    end
    expect_out("waw_done", 0, 0, 0, 1, 1, 10);
    tick();
    flush(2, 10);

    // reset mid-operation drops the MDU op
    drive(1, 0, 0, 0, 0, 0, 8, 0, 1);
    expect_out("rs_iss", 0, 0, 0, 0, 0, 10);
    tick();
    idle();
    expect_out("rs_busy", 0, 0, 0, 1, 0, 8);
    tick();
    resetn = 1'b0;
    expect_out("rs_mid", 0, 0, 0, 0, 0, 0);
    tick();
    resetn = 1'b1;
    drive(1, 8, 8, 1, 1, 1, 9, 0, 0);
    expect_out("rs_use", 0, 0, 0, 0, 0, 0);
    tick();
    flush(4, 0);

    chk("sb_empty", 32'(q_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
